tdm_demux4: RTL

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_demux_pkg.sv | 6 +
 rtl/tdm_slot_ctr.sv | 19 +
 rtl/tdm_demux4.sv | 99 +++++++++
 3 files changed

// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared FSM state, slot count and slot index type for the TDM demultiplexer
package tdm_demux_pkg;
  typedef enum logic {HUNT, LOCKED} state_t;
  localparam int NUM_SLOTS = 4;
  typedef logic [1:0] slot_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit TDM slot counter with clear, realign-to-slot-1 and modulo-4 increment
// Ports: clk, rst_n (async, active-low), clr -> 0, load1 -> 1, inc -> +1 mod 4, slot = current slot
module tdm_slot_ctr
  import tdm_demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  load1,
  input  logic  inc,
  output slot_t slot
);
  slot_t slot_q, slot_d;
  always_comb slot_d = clr ? slot_t'(0) : load1 ? slot_t'(1) : inc ? slot_q + slot_t'(1) : slot_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slot_q <= '0;
    else slot_q <= slot_d;
  assign slot = slot_q;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: four-slot TDM demultiplexer with frame-start alignment, sync and optional parity checking
// Ports: clk, rst_n (async, active-low), din/din_valid/frame_start beat input,
//   y0..y3 channel registers, y_valid per-channel update pulse, frame_done, sync_err, locked.
// Option TDM_DEMUX_PARITY_EN adds din_par (even parity over din) and parity_err.
module tdm_demux4 #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_start,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic             din_par,
  output logic             parity_err,
`endif
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  output logic             frame_done,
  output logic             sync_err,
  output logic             locked
);
  import tdm_demux_pkg::*;
  state_t state_q, state_d;
  slot_t slot;
  logic [NUM_SLOTS-1:0][WIDTH-1:0] y_q, y_d;
  logic [NUM_SLOTS-1:0] y_valid_q, y_valid_d;
  logic frame_done_q, frame_done_d, sync_err_q, sync_err_d, parity_err_q, parity_err_d;
  logic par_bad, clr, load1, inc;
  tdm_slot_ctr u_ctr (.clk(clk), .rst_n(rst_n), .clr(clr), .load1(load1), .inc(inc), .slot(slot));
  // Frame completeness is implicit: slot 3 is reachable only by in-order beats after a slot-0 write.
  always_comb begin
`ifdef TDM_DEMUX_PARITY_EN
    par_bad = din_valid && (state_q == LOCKED || frame_start) && ((^din) != din_par);
`else
    par_bad = 1'b0;
`endif
    state_d = state_q;
    y_d = y_q;
    y_valid_d = '0;
    frame_done_d = 1'b0;
    sync_err_d = 1'b0;
    parity_err_d = par_bad;
    clr = 1'b0;
    load1 = 1'b0;
    inc = 1'b0;
    if (par_bad) begin
      state_d = HUNT;
      clr = 1'b1;
    end else if (din_valid && frame_start) begin
      y_d[0] = din;
      y_valid_d = 4'b0001;
      load1 = 1'b1;
      state_d = LOCKED;
      sync_err_d = (state_q == LOCKED) && (slot != slot_t'(0));
    end else if (din_valid && state_q == LOCKED) begin
      if (slot == slot_t'(0)) begin
        sync_err_d = 1'b1;
        state_d = HUNT;
        clr = 1'b1;
      end else begin
        y_d[slot] = din;
        y_valid_d[slot] = 1'b1;
        frame_done_d = (slot == slot_t'(NUM_SLOTS - 1));
        inc = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= HUNT;
      y_q <= '0;
      y_valid_q <= '0;
      frame_done_q <= 1'b0;
      sync_err_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q <= y_d;
      y_valid_q <= y_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q <= sync_err_d;
      parity_err_q <= parity_err_d;
    end
  assign {y3, y2, y1, y0} = y_q;
  assign y_valid = y_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err = sync_err_q;
  assign locked = (state_q == LOCKED);
`ifdef TDM_DEMUX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  logic unused_par;
  assign unused_par = parity_err_q;
`endif
endmodule
